// File: rtl/mem_port_arbiter.sv
// Purpose : share one synchronous single-port SRAM between the instruction-fetch and data ports.
// Latency : grant is combinational in the request cycle; rvalid/rdata follow one cycle later.
// Backpr. : a request that is not granted must be held; there is no backpressure on responses.
//
// Optional feature macro: MEM_ARB_PERF_EN
//   Defined     -> adds the perf_inst_wait / perf_conflict saturating counters as outputs.
//   Not defined -> those ports and counters do not exist; everything else is unchanged.
//
// Ports
//   clk, resetn                        clock and synchronous active-low reset
//   inst_req/addr -> inst_gnt          fetch request and its same-cycle accept
//   inst_rvalid/rdata                  fetch data, one cycle after inst_gnt
//   data_req/we/addr/wdata -> data_gnt load/store request and its same-cycle accept
//   data_rvalid/rdata                  load data or store ack, one cycle after data_gnt
//   sram_en/we/addr/wdata, sram_rdata  unified memory macro interface
//   perf_inst_wait, perf_conflict      (MEM_ARB_PERF_EN only) event counters
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              resetn,
   // instruction-fetch port
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [DATA_W-1:0] inst_rdata,
   // data port
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   // unified SRAM
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_inst_wait,
   output logic [31:0]       perf_conflict
`endif
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
   localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);

   typedef enum logic {
      PRI_DATA = 1'b0,
      PRI_INST = 1'b1
   } prio_t;

   prio_t          prio;
   logic [WCW-1:0] wait_cnt;
   logic           rsp_inst;
   logic           rsp_data;
   logic           rsp_wr;

   // ------------------------------------------------------------------
   // Grant: a lone requester always wins; on a conflict the priority
   // state decides. Both grants are gated off while reset is asserted,
   // which also keeps the SRAM strobes quiet during reset.
   // ------------------------------------------------------------------
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (resetn) begin
         if (inst_req && data_req) begin
            inst_gnt = (prio == PRI_INST);
            data_gnt = (prio == PRI_DATA);
         end else begin
            inst_gnt = inst_req;
            data_gnt = data_req;
         end
      end
   end

   // ------------------------------------------------------------------
   // SRAM drive: address and write data come from the granted port.
   // Idle cycles and fetches drive zero write data so the bus is quiet.
   // ------------------------------------------------------------------
   always_comb begin
      sram_en    = inst_gnt | data_gnt;
      sram_we    = data_gnt & data_we;
      sram_addr  = '0;
      sram_wdata = '0;
      if (data_gnt) begin
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end else if (inst_gnt) begin
         sram_addr  = inst_addr;
      end
   end

   // ------------------------------------------------------------------
   // Priority FSM, starvation counter and response tracking.
   // The fetch port is switched to priority on the last denied cycle
   // of its budget, so it wins the very next conflict; it hands
   // priority back as soon as it has been served once.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         prio     <= PRI_DATA;
         wait_cnt <= '0;
         rsp_inst <= 1'b0;
         rsp_data <= 1'b0;
         rsp_wr   <= 1'b0;
      end else begin
         case (prio)
            PRI_DATA: if (inst_req && !inst_gnt && wait_cnt == WAIT_LAST) prio <= PRI_INST;
            PRI_INST: if (inst_gnt)                                       prio <= PRI_DATA;
            default:                                                      prio <= PRI_DATA;
         endcase

         if (inst_gnt || !inst_req)
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_SAT)
            wait_cnt <= wait_cnt + 1'b1;

         rsp_inst <= inst_gnt;
         rsp_data <= data_gnt;
         rsp_wr   <= data_gnt & data_we;
      end
   end

   // Read data is steered to the owning port and zeroed otherwise, so
   // a store ack never carries stale SRAM output.
   assign inst_rvalid = rsp_inst;
   assign data_rvalid = rsp_data;
   assign inst_rdata  = rsp_inst ? sram_rdata : '0;
   assign data_rdata  = (rsp_data && !rsp_wr) ? sram_rdata : '0;

`ifdef MEM_ARB_PERF_EN
   // Saturating event counters: fetch cycles spent waiting, and cycles
   // in which both ports requested at once.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_inst_wait <= '0;
         perf_conflict  <= '0;
      end else begin
         if (inst_req && !inst_gnt && perf_inst_wait != 32'hFFFF_FFFF)
            perf_inst_wait <= perf_inst_wait + 32'd1;
         if (inst_req && data_req && perf_conflict != 32'hFFFF_FFFF)
            perf_conflict <= perf_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, between active edges.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk;
   logic              resetn;
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_gnt;
   logic              inst_rvalid;
   logic [DATA_W-1:0] inst_rdata;
   logic              data_req;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_gnt;
   logic              data_rvalid;
   logic [DATA_W-1:0] data_rdata;
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]       perf_inst_wait;
   logic [31:0]       perf_conflict;
`endif

   int checks;
   int failures;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .sram_en     (sram_en),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_inst_wait (perf_inst_wait),
      .perf_conflict  (perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; caller then drives inputs and waits #1.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      logic [9:0] pat;
      checks     = 0;
      failures   = 0;
      resetn     = 1'b0;
      inst_req   = 1'b0;
      inst_addr  = '0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_addr  = '0;
      data_wdata = '0;
      sram_rdata = '0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      next_cycle();
      inst_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
      inst_addr = 32'h40; data_addr = 32'h80; data_wdata = 32'h1111_2222;
      #1;
      chk("rst_inst_gnt", inst_gnt, 0);
      chk("rst_data_gnt", data_gnt, 0);
      chk("rst_sram_en",  sram_en,  0);
      chk("rst_sram_we",  sram_we,  0);
      chk("rst_inst_rvalid", inst_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
      next_cycle();
      resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
      #1;
      chk("idle_sram_en",   sram_en,   0);
      chk("idle_sram_addr", sram_addr, 0);
      chk("idle_sram_wdata", sram_wdata, 0);
`ifdef MEM_ARB_PERF_EN
      chk("rst_perf_conflict", perf_conflict, 0);
`endif

      // ---------------- 1: fetch only ----------------
      next_cycle();
      inst_req = 1'b1; inst_addr = 32'h1c00_0000;
      #1;
      chk("t1_inst_gnt",  inst_gnt,  1);
      chk("t1_data_gnt",  data_gnt,  0);
      chk("t1_sram_en",   sram_en,   1);
      chk("t1_sram_we",   sram_we,   0);
      chk("t1_sram_addr", sram_addr, 32'h1c00_0000);
      chk("t1_inst_rvalid_early", inst_rvalid, 0);
      next_cycle();
      inst_req = 1'b0; sram_rdata = 32'h0280_0421;
      #1;
      chk("t1_inst_rvalid", inst_rvalid, 1);
      chk("t1_inst_rdata",  inst_rdata,  32'h0280_0421);
      chk("t1_data_rvalid", data_rvalid, 0);
      chk("t1_data_rdata",  data_rdata,  0);

      // ---------------- 2: store, then load ----------------
      next_cycle();
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
      sram_rdata = 32'h55AA_55AA;
      #1;
      chk("t2_data_gnt",   data_gnt,   1);
      chk("t2_sram_we",    sram_we,    1);
      chk("t2_sram_addr",  sram_addr,  32'h100);
      chk("t2_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
      chk("t2_inst_rvalid_clear", inst_rvalid, 0);
      chk("t2_inst_rdata_clear",  inst_rdata,  0);
      next_cycle();
      data_we = 1'b0; data_addr = 32'h200; data_wdata = 32'h0;
      #1;
      chk("t2_store_rvalid", data_rvalid, 1);
      chk("t2_store_rdata",  data_rdata,  0);
      chk("t2_load_sram_we", sram_we,     0);
      chk("t2_load_gnt",     data_gnt,    1);
      next_cycle();
      data_req = 1'b0; sram_rdata = 32'h1234_5678;
      #1;
      chk("t2_load_rvalid", data_rvalid, 1);
      chk("t2_load_rdata",  data_rdata,  32'h1234_5678);

      // ---------------- 3: sustained conflict ----------------
      // Expected owner per cycle, bit i = 1 means fetch wins cycle i.
      pat = 10'b10_0001_0000;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         inst_req = 1'b1; inst_addr = 32'h1c00_0000 + 32'(4 * i);
         data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300 + 32'(4 * i);
         #1;
         chk($sformatf("t3_inst_gnt_c%0d", i), inst_gnt, pat[i]);
         chk($sformatf("t3_data_gnt_c%0d", i), data_gnt, !pat[i]);
         chk($sformatf("t3_sram_addr_c%0d", i), sram_addr,
             pat[i] ? 32'h1c00_0000 + 32'(4 * i) : 32'h300 + 32'(4 * i));
         chk($sformatf("t3_wait_cnt_c%0d", i), dut.wait_cnt, i % 5);
      end

      // ---------------- 4: data drops while fetch has priority ----------------
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         #1;
         if (i == 0) begin
`ifdef MEM_ARB_PERF_EN
            chk("t6_perf_conflict",  perf_conflict,  10);
            chk("t6_perf_inst_wait", perf_inst_wait, 8);
`endif
            chk("t3_wait_cnt_after", dut.wait_cnt, 0);
         end
         chk($sformatf("t4_pre_data_gnt_c%0d", i), data_gnt, 1);
      end
      next_cycle();
      data_req = 1'b0;
      #1;
      chk("t4_wait_cnt_full", dut.wait_cnt, 4);
      chk("t4_inst_gnt",      inst_gnt,      1);
      next_cycle();
      data_req = 1'b1;
      #1;
      chk("t4_prio_back_data", data_gnt, 1);
      chk("t4_inst_denied",    inst_gnt, 0);
      chk("t4_wait_cnt_clear", dut.wait_cnt, 0);

      // ---------------- 5: reset right after a load grant ----------------
      // Three more data wins (cycles 1..3 of a new wait budget): the last
      // one is a load grant that also moves priority to the fetch port.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         #1;
         chk($sformatf("t5_load_gnt_c%0d", i), data_gnt, 1);
      end
      next_cycle();
      resetn = 1'b0;
      #1;
      chk("t5_rst_inst_gnt", inst_gnt, 0);
      chk("t5_rst_data_gnt", data_gnt, 0);
      chk("t5_rst_sram_en",  sram_en,  0);
      chk("t5_rst_sram_we",  sram_we,  0);
      next_cycle();
      resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;
      #1;
      chk("t5_no_data_rvalid", data_rvalid, 0);
      chk("t5_no_inst_rvalid", inst_rvalid, 0);
      chk("t5_data_rdata",     data_rdata,  0);
      chk("t5_wait_cnt",       dut.wait_cnt, 0);
`ifdef MEM_ARB_PERF_EN
      chk("t5_perf_conflict", perf_conflict, 0);
`endif
      next_cycle();
      inst_req = 1'b1; data_req = 1'b1;
      #1;
      chk("t5_prio_data_gnt", data_gnt, 1);
      chk("t5_prio_inst_gnt", inst_gnt, 0);
      next_cycle();
      inst_req = 1'b0; data_req = 1'b0;
      #1;
      chk("t5_rvalid_resume", data_rvalid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
